muldiv_unit: RTL and testbench

Iterative multiply/divide execution unit for the 16-bit core. Consumes the two register-file read operands (ar/br) when an extended arithmetic instruction issues. Produces a single-word result plus a write-back request (address, enable, data) that feeds the register-file write port through the write-back mux. Multi-cycle: the issue logic stalls on busy.

---
 rtl/muldiv_pkg.sv | 7 +
 rtl/muldiv_step.sv | 20 ++
 rtl/muldiv_unit.sv | 116 +++++++++++
 tb/tb_muldiv_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and constants shared by the multiply/divide unit.
package muldiv_pkg;
    localparam int WIDTH_DEF = 16;
    localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;
    typedef enum logic [1:0] {MUL_LO = 2'b00, MUL_HI = 2'b01, DIV = 2'b10, REM = 2'b11} op_e;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one iteration of shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0] sum, rem_sh, diff;
    // MUL: {hi,lo} with multiplier bits consumed from lo; DIV: {rem,dividend->quotient}
    assign sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : '0);
    assign rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    assign diff   = rem_sh - {1'b0, b_i};
    assign acc_o  = !is_div_i   ? {sum, acc_i[WIDTH-1:1]}
                  : diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0}
                  :               {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative WIDTH-cycle multiply/divide with register write-back request.
// Define MULDIV_SIGNED_EN to add the op_signed port for two's-complement operation.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] dest,
`ifdef MULDIV_SIGNED_EN
    input  logic              op_signed,
`endif
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              div_zero
);
    localparam int CW = $clog2(WIDTH);
    state_e             state_q;
    op_e                op_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0]   b_q, a_mag, b_mag, quo, rem, res_d, result_q;
    logic [ADDR_W-1:0]  dest_q, wr_addr_q;
    logic               neg_q, neg_d, busy_q, done_q, div_zero_q;
`ifdef MULDIV_SIGNED_EN
    logic sa, sb;
    assign sa    = op_signed & a[WIDTH-1];
    assign sb    = op_signed & b[WIDTH-1];
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;
    assign neg_d = (op == REM) ? sa : sa ^ sb;
`else
    assign a_mag = a;
    assign b_mag = b;
    assign neg_d = 1'b0;
`endif
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i(op_q[1]),
        .acc_i   (acc_q),
        .b_i     (b_q),
        .acc_o   (acc_d)
    );
    // Sign fix-up is applied to the final iteration's output as DONE is entered
    assign prod  = neg_q ? -acc_d : acc_d;
    assign quo   = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    assign rem   = neg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
    assign res_d = (op_q == MUL_LO) ? prod[WIDTH-1:0]
                 : (op_q == MUL_HI) ? prod[2*WIDTH-1:WIDTH]
                 : (op_q == DIV)    ? quo : rem;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= MUL_LO;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            dest_q     <= '0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            wr_addr_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    op_q   <= op_e'(op);
                    cnt_q  <= '0;
                    acc_q  <= {{WIDTH{1'b0}}, a_mag};
                    b_q    <= b_mag;
                    dest_q <= dest;
                    neg_q  <= neg_d;
                    busy_q <= 1'b1;
                    if (op[1] && b == '0) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        result_q   <= op[0] ? a : WIDTH'(DIV0_QUOT);
                        wr_addr_q  <= dest;
                        div_zero_q <= 1'b1;
                    end else begin
                        state_q    <= S_RUN;
                        div_zero_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        result_q  <= res_d;
                        wr_addr_q <= dest_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign wr_addr  = wr_addr_q;
    assign div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clock = 0, reset = 1, start = 0, sgn = 0;
    logic [1:0]  op = 0;
    logic [15:0] a = 0, b = 0;
    logic [2:0]  dest = 0;
    logic        busy, done, div_zero;
    logic [15:0] result;
    logic [2:0]  wr_addr;
    int n_chk = 0, n_pass = 0;

    muldiv_unit dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b), .dest(dest),
`ifdef MULDIV_SIGNED_EN
        .op_signed(sgn),
`endif
        .busy(busy), .done(done), .result(result), .wr_addr(wr_addr), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic s);
        int xi, yi, q, r;
        longint p;
        xi = x;
        yi = y;
        if (s) begin
            xi = $signed(x);
            yi = $signed(y);
        end
        p = longint'(xi) * longint'(yi);
        if (o[1] && y == 0) return o[0] ? x : 16'hFFFF;
        q = o[1] ? xi / yi : 0;
        r = o[1] ? xi % yi : 0;
        case (o)
            2'd0: return p[15:0];
            2'd1: return p[31:16];
            2'd2: return q[15:0];
            default: return r[15:0];
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input logic [2:0] d, input logic s);
        int lat = 0;
        logic dz;
        dz = o[1] && y == 0;
        @(negedge clock);
        start = 1; op = o; a = x; b = y; dest = d; sgn = s;
        @(posedge clock); #1;
        start = 0; a = 16'($urandom); b = 16'($urandom); dest = 3'($urandom); sgn = 1'($urandom);
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        check("latency", lat, dz ? 0 : 16);
        check("result", result, model(o, x, y, s));
        check("wr_addr", wr_addr, d);
        check("div_zero", div_zero, dz);
        check("busy_in_done", busy, 1);
        @(posedge clock); #1;
        check("done_width", done, 0);
        check("busy_after", busy, 0);
        check("result_hold", result, model(o, x, y, s));
    endtask

    initial begin
        logic [15:0] expq[$];
        logic [15:0] ra, rb;
        logic [1:0]  ro;
        int last, ndone, bad_dz;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_div_zero", div_zero, 0);
        reset = 0;
        run_op(2'd0, 16'd300, 16'd500, 3'd3, 0);
        run_op(2'd1, 16'd300, 16'd500, 3'd3, 0);
        run_op(2'd2, 16'd1000, 16'd7, 3'd5, 0);
        run_op(2'd3, 16'd1000, 16'd7, 3'd6, 0);
        run_op(2'd2, 16'h1234, 16'd0, 3'd1, 0);
        run_op(2'd3, 16'h1234, 16'd0, 3'd2, 0);
        run_op(2'd0, 16'hFFFF, 16'hFFFF, 3'd7, 0);
        run_op(2'd1, 16'hFFFF, 16'hFFFF, 3'd7, 0);
        run_op(2'd2, 16'hFFFF, 16'd1, 3'd4, 0);
`ifdef MULDIV_SIGNED_EN
        run_op(2'd2, 16'hFFF9, 16'd2, 3'd1, 1);
        run_op(2'd3, 16'hFFF9, 16'd2, 3'd1, 1);
        run_op(2'd2, 16'h8000, 16'hFFFF, 3'd2, 1);
        run_op(2'd3, 16'h8000, 16'hFFFF, 3'd2, 1);
        run_op(2'd1, 16'hFFFD, 16'd5, 3'd3, 1);
        run_op(2'd3, 16'hFFF9, 16'd0, 3'd3, 1);
`endif
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
`ifdef MULDIV_SIGNED_EN
            run_op(ro, 16'($urandom), rb, 3'($urandom), 1'($urandom));
`else
            run_op(ro, 16'($urandom), rb, 3'($urandom), 0);
`endif
        end
        // start held high with operands changing every cycle
        last = -1; ndone = 0; bad_dz = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clock);
            ro = 2'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom_range(1, 65535));
            start = 1; op = ro; a = ra; b = rb; sgn = 0;
            if (!busy) expq.push_back(model(ro, ra, rb, 0));
            @(posedge clock); #1;
            if (done) begin
                if (last >= 0) check("b2b_spacing", c - last, 18);
                if (expq.size() > 0) check("b2b_result", result, expq.pop_front());
                else check("b2b_unexpected_done", 1, 0);
                last = c;
                ndone++;
                @(negedge clock);
                start = 1; a = 16'($urandom); b = 16'($urandom_range(1, 65535));
                @(posedge clock); #1;
                c++;
                check("b2b_done_width", done, 0);
            end
        end
        start = 0;
        check("b2b_count", ndone >= 5, 1);
        while (busy) @(posedge clock);
        #1;
        // reset in the middle of a divide
        @(negedge clock);
        start = 1; op = 2'd2; a = 16'd1000; b = 16'd7; dest = 3'd5;
        @(posedge clock); #1;
        start = 0;
        repeat (7) begin
            @(posedge clock); #1;
            if (done) bad_dz++;
        end
        @(negedge clock);
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        check("abort_no_done", bad_dz + done, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_wr_addr", wr_addr, 0);
        repeat (20) begin
            @(posedge clock); #1;
            if (done) bad_dz++;
        end
        check("abort_late_done", bad_dz, 0);
        run_op(2'd0, 16'd3, 16'd4, 3'd2, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end
endmodule
